// File: rtl/branch_predictor_btb_if.sv
// Fetch-lookup / execute-update bus of the branch target buffer.
// BP_STATS_EN adds the prediction-accuracy counter signals.
interface branch_predictor_btb_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] pcF;
    logic            predHitF;
    logic            predTakenF;
    logic [XLEN-1:0] predTargetF;
    logic            updValidE;
    logic [XLEN-1:0] updPcE;
    logic            updTakenE;
    logic            updJumpE;
    logic [XLEN-1:0] updTargetE;
    logic            btbFlush;
`ifdef BP_STATS_EN
    logic            updPredTakenE;
    logic [31:0]     statBranches;
    logic [31:0]     statMispredicts;

    modport master (
        output pcF, updValidE, updPcE, updTakenE, updJumpE, updTargetE, btbFlush,
               updPredTakenE,
        input  predHitF, predTakenF, predTargetF, statBranches, statMispredicts
    );
    modport slave (
        input  pcF, updValidE, updPcE, updTakenE, updJumpE, updTargetE, btbFlush,
               updPredTakenE,
        output predHitF, predTakenF, predTargetF, statBranches, statMispredicts
    );
`else
    modport master (
        output pcF, updValidE, updPcE, updTakenE, updJumpE, updTargetE, btbFlush,
        input  predHitF, predTakenF, predTargetF
    );
    modport slave (
        input  pcF, updValidE, updPcE, updTakenE, updJumpE, updTargetE, btbFlush,
        output predHitF, predTakenF, predTargetF
    );
`endif
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit saturating direction counters; combinational fetch lookup,
// execute-stage training. Define BP_STATS_EN for branch/mispredict counters.
module branch_predictor_btb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ENTRIES  = 16,
    parameter logic [1:0]  CTR_INIT = 2'b01
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_predictor_btb_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - 2 - IDX_W;

    logic [ENTRIES-1:0] valid;
    logic [1:0]         ctr        [ENTRIES];
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [XLEN-1:0]    target_mem [ENTRIES];

    // Fetch-side lookup, reads pre-update storage
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic             f_taken;

    assign f_idx   = bus.pcF[IDX_W+1:2];
    assign f_tag   = bus.pcF[XLEN-1:IDX_W+2];
    assign f_hit   = valid[f_idx] && (tag_mem[f_idx] == f_tag);
    assign f_taken = f_hit && ctr[f_idx][1];

    assign bus.predHitF    = f_hit;
    assign bus.predTakenF  = f_taken;
    assign bus.predTargetF = f_taken ? target_mem[f_idx] : bus.pcF + XLEN'(4);

    // Execute-side training; a jump reported as not-taken is treated as taken
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             u_taken;
    logic [1:0]       u_ctr_cur;
    logic [1:0]       ctr_next;
    logic             ctr_we;
    logic             data_we;

    assign u_idx     = bus.updPcE[IDX_W+1:2];
    assign u_tag     = bus.updPcE[XLEN-1:IDX_W+2];
    assign u_hit     = valid[u_idx] && (tag_mem[u_idx] == u_tag);
    assign u_taken   = bus.updTakenE || bus.updJumpE;
    assign u_ctr_cur = ctr[u_idx];
    assign ctr_we    = bus.updValidE && (u_hit || u_taken);
    assign data_we   = bus.updValidE && u_taken;

    always_comb begin
        ctr_next = u_ctr_cur;
        if (!u_hit) begin
            ctr_next = bus.updJumpE ? 2'b11 : 2'b10;
        end else if (bus.updJumpE) begin
            ctr_next = 2'b11;
        end else if (u_taken) begin
            if (u_ctr_cur != 2'b11) ctr_next = u_ctr_cur + 2'd1;
        end else begin
            if (u_ctr_cur != 2'b00) ctr_next = u_ctr_cur - 2'd1;
        end
    end

    // Valid bits and counters: reset and flush restore the weak not-taken state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) ctr[i] <= CTR_INIT;
        end else if (bus.btbFlush) begin
            valid <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) ctr[i] <= CTR_INIT;
        end else begin
            if (ctr_we)  ctr[u_idx]   <= ctr_next;
            if (data_we) valid[u_idx] <= 1'b1;
        end
    end

    // Tag/target carry no reset: they are only observed behind a set valid bit
    always_ff @(posedge clk) begin
        if (data_we && !bus.btbFlush) begin
            tag_mem[u_idx]    <= u_tag;
            target_mem[u_idx] <= bus.updTargetE;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] branches;
    logic [31:0] mispredicts;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branches    <= '0;
            mispredicts <= '0;
        end else if (bus.updValidE) begin
            branches <= branches + 32'd1;
            if (bus.updPredTakenE != bus.updTakenE) mispredicts <= mispredicts + 32'd1;
        end
    end

    assign bus.statBranches    = branches;
    assign bus.statMispredicts = mispredicts;
`endif

    // Byte-offset bits never take part in index or tag
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.pcF[1:0], bus.updPcE[1:0]};

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed + randomized bench for branch_predictor_btb against a line-address BTB model.
// Stats checks are compiled in when BP_STATS_EN is defined.
module tb_branch_predictor_btb;
    localparam int unsigned N = 16;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    branch_predictor_btb_if #(.XLEN(32)) bif ();

    branch_predictor_btb #(.XLEN(32), .ENTRIES(N), .CTR_INIT(2'b01)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    // Model: each slot remembers the full word address (pc>>2) it holds
    bit          m_valid [N];
    logic [29:0] m_line  [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    int unsigned m_br;
    int unsigned m_mis;

    function automatic int slot_of(logic [31:0] pc);
        return int'((pc >> 2) % 32'(N));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(N); i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_br  = 0;
        m_mis = 0;
    endtask

    task automatic model_predict(input logic [31:0] pc, output logic hit, output logic taken,
                                 output logic [31:0] tgt);
        int s;
        s     = slot_of(pc);
        hit   = m_valid[s] && (m_line[s] == pc[31:2]);
        taken = hit && (m_ctr[s] >= 2);
        tgt   = taken ? m_tgt[s] : pc + 32'd4;
    endtask

    // Applies what the DUT saw at this clock edge
    task automatic model_step();
        int   s;
        logic hit;
        logic tk;
        if (!reset) return;
        if (bif.updValidE) begin
            m_br++;
`ifdef BP_STATS_EN
            if (bif.updPredTakenE != bif.updTakenE) m_mis++;
`endif
        end
        if (bif.btbFlush) begin
            for (int i = 0; i < int'(N); i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
            end
        end else if (bif.updValidE) begin
            s   = slot_of(bif.updPcE);
            hit = m_valid[s] && (m_line[s] == bif.updPcE[31:2]);
            tk  = bif.updTakenE || bif.updJumpE;
            if (hit) begin
                if (bif.updJumpE) m_ctr[s] = 3;
                else if (tk)      m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
                else              m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
                if (tk) m_tgt[s] = bif.updTargetE;
            end else if (tk) begin
                m_valid[s] = 1'b1;
                m_line[s]  = bif.updPcE[31:2];
                m_tgt[s]   = bif.updTargetE;
                m_ctr[s]   = bif.updJumpE ? 3 : 2;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        bif.updValidE = 1'b0;
        bif.btbFlush  = 1'b0;
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic tk, input logic jmp,
                             input logic [31:0] tgt, input logic ptk);
        bif.updValidE  = 1'b1;
        bif.updPcE     = pc;
        bif.updTakenE  = tk;
        bif.updJumpE   = jmp;
        bif.updTargetE = tgt;
`ifdef BP_STATS_EN
        bif.updPredTakenE = ptk;
`else
        if (ptk) bif.updTargetE = tgt;
`endif
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic jmp,
                       input logic [31:0] tgt, input logic ptk);
        drive_upd(pc, tk, jmp, tgt, ptk);
        tick();
        idle();
    endtask

    // Lookup against fixed expectations
    task automatic look_exp(input string name, input logic [31:0] pc, input logic hit,
                            input logic tk, input logic [31:0] tgt);
        bif.pcF = pc;
        #1;
        check({name, ".hit"},    32'(bif.predHitF),   32'(hit));
        check({name, ".taken"},  32'(bif.predTakenF), 32'(tk));
        check({name, ".target"}, bif.predTargetF,     tgt);
    endtask

    // Lookup against the model
    task automatic look_model(input string name, input logic [31:0] pc);
        logic        hit;
        logic        tk;
        logic [31:0] tgt;
        model_predict(pc, hit, tk, tgt);
        look_exp(name, pc, hit, tk, tgt);
    endtask

    task automatic check_stats(input string name);
`ifdef BP_STATS_EN
        check({name, ".branches"},    bif.statBranches,    m_br);
        check({name, ".mispredicts"}, bif.statMispredicts, m_mis);
`else
        if (name.len() == 0) m_br = m_br;
`endif
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
            | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) p = p | 32'hFFFF_FF00;
        return p;
    endfunction

    initial begin
        reset = 1'b0;
        model_reset();
        bif.pcF        = 32'h100;
        bif.updPcE     = '0;
        bif.updTakenE  = 1'b0;
        bif.updJumpE   = 1'b0;
        bif.updTargetE = '0;
`ifdef BP_STATS_EN
        bif.updPredTakenE = 1'b0;
`endif
        idle();
        #2;
        look_exp("reset_lookup", 32'h100, 1'b0, 1'b0, 32'h104);
        look_exp("reset_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        check_stats("reset_stats");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Allocation, then counter hysteresis on one entry
        upd(32'h100, 1'b1, 1'b0, 32'h80, 1'b0);
        look_exp("alloc", 32'h100, 1'b1, 1'b1, 32'h80);
        drive_upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
        look_exp("same_cycle", 32'h100, 1'b1, 1'b1, 32'h80);
        tick();
        idle();
        look_exp("nt1", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        look_exp("nt2", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        look_exp("nt3_sat", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 1'b0, 32'h88, 1'b0);
        look_exp("t1_from00", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 1'b0, 32'h88, 1'b0);
        look_exp("t2_to10", 32'h100, 1'b1, 1'b1, 32'h88);

        // Aliasing in slot 0
        upd(32'h140, 1'b1, 1'b0, 32'h300, 1'b0);
        look_exp("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
        look_exp("alias_new", 32'h140, 1'b1, 1'b1, 32'h300);

        // Jump, then flush that wins over a same-edge update
        upd(32'h20, 1'b1, 1'b1, 32'h200, 1'b0);
        look_exp("jal", 32'h20, 1'b1, 1'b1, 32'h200);
        upd(32'h24, 1'b1, 1'b0, 32'h240, 1'b0);
        look_exp("br24", 32'h24, 1'b1, 1'b1, 32'h240);
        drive_upd(32'h24, 1'b1, 1'b0, 32'h999, 1'b0);
        bif.btbFlush = 1'b1;
        tick();
        idle();
        look_exp("flush_20", 32'h20, 1'b0, 1'b0, 32'h24);
        look_exp("flush_24", 32'h24, 1'b0, 1'b0, 32'h28);
        look_exp("flush_140", 32'h140, 1'b0, 1'b0, 32'h144);

        // Jump reported not-taken still counts as taken; low PC bits ignored
        upd(32'h30, 1'b0, 1'b1, 32'h400, 1'b0);
        look_exp("jmp_nt", 32'h30, 1'b1, 1'b1, 32'h400);
        upd(32'h30, 1'b0, 1'b0, 32'h0, 1'b1);
        look_exp("after_nt_11", 32'h30, 1'b1, 1'b1, 32'h400);
        look_exp("misaligned", 32'h33, 1'b1, 1'b1, 32'h400);
        look_exp("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

        // Reset asserted while an update is pending
        drive_upd(32'h40, 1'b1, 1'b0, 32'h500, 1'b0);
        #2;
        reset = 1'b0;
        model_reset();
        look_exp("rst_mid_30", 32'h30, 1'b0, 1'b0, 32'h34);
        check_stats("rst_mid_stats");
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle();
        look_exp("rst_dropped", 32'h40, 1'b0, 1'b0, 32'h44);

        // Five resolved branches, two mispredicted
        upd(32'h50, 1'b1, 1'b0, 32'h500, 1'b1);
        upd(32'h50, 1'b1, 1'b0, 32'h500, 1'b0);
        upd(32'h54, 1'b0, 1'b0, 32'h0,   1'b0);
        upd(32'h54, 1'b0, 1'b0, 32'h0,   1'b1);
        upd(32'h58, 1'b1, 1'b1, 32'h580, 1'b1);
`ifdef BP_STATS_EN
        check("stats5.branches",    bif.statBranches,    32'd5);
        check("stats5.mispredicts", bif.statMispredicts, 32'd2);
`endif
        look_model("post_stats", 32'h58);

        // Randomized traffic, lookups sampled before each edge
        for (int it = 0; it < 600; it++) begin
            logic jmp;
            jmp = ($urandom_range(0, 7) == 0);
            drive_upd(rand_pc(), 1'($urandom_range(0, 1)), jmp, $urandom(),
                      1'($urandom_range(0, 1)));
            bif.updValidE = ($urandom_range(0, 3) != 0);
            bif.btbFlush  = ($urandom_range(0, 39) == 0);
            look_model("rand", ($urandom_range(0, 3) == 0) ? bif.updPcE : rand_pc());
            tick();
            if (it % 32 == 31) check_stats("rand_stats");
        end
        idle();
        look_model("final", 32'h100);
        check_stats("final_stats");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
